wshb_frame_slave: RTL

//  Wishbone classic-cycle responder holding one frame of 32-bit pixel words in on-chip RAM.

---
 rtl/wshb_frame_slave_if.sv | 24 ++
 rtl/wshb_frame_slave.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/wshb_frame_slave_if.sv
// Wishbone classic bus bundle between a pixel read master and the frame slave.
interface wshb_frame_slave_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_sm;
  logic        ack;
  logic        err;

  modport master (
    output cyc, stb, we, adr, dat_ms, sel, cti, bte,
    input  dat_sm, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
    output dat_sm, ack, err
  );
endinterface

// File: rtl/wshb_frame_slave.sv
// Wishbone classic slave serving one frame of 32-bit pixel words from on-chip RAM.
// Define WSHB_FRAME_PATTERN_EN to answer read misses with an address-derived test pattern.
module wshb_frame_slave #(
  parameter int unsigned HDISP       = 800,
  parameter int unsigned VDISP       = 480,
  parameter int unsigned DEPTH       = HDISP * VDISP,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic               clk,
  input  logic               rst,
  wshb_frame_slave_if.slave  bus,
  output logic               frame_tick
);

  localparam int unsigned FRAME    = HDISP * VDISP;
  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WaitInit = 4'(WAIT_STATES);
  localparam logic [29:0] LastIdx  = 30'(FRAME - 1);
  localparam logic [30:0] DepthW   = 31'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;
  typedef enum logic [1:0] {DatZero, DatRam, DatPat} dat_src_e;

  state_e      state_q, state_d;
  dat_src_e    src_q, src_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [29:0] idx_q, idx_d;
  logic        we_q, we_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        tick_q, tick_d;
`ifdef WSHB_FRAME_PATTERN_EN
  logic [31:0] pat_q, pat_d;
`endif

  logic        req;
  logic        fire;
  logic        from_bus;
  logic [29:0] f_idx;
  logic        f_we;
  logic [31:0] f_dat;
  logic [3:0]  f_sel;
  logic        f_hit;
  logic        ram_wr_en;
  logic        ram_rd_en;

  logic [31:0] mem [DEPTH];
  logic [31:0] ram_rd_q;

  logic unused_bus;
  assign unused_bus = ^{bus.cti, bus.bte, bus.adr[1:0]};

  assign req = bus.cyc & bus.stb;

  // With no wait states the response fires straight from IDLE, so the request
  // fields come from the bus rather than the capture registers.
  always_comb begin
    from_bus = (state_q == StIdle);
    f_idx    = from_bus ? bus.adr[31:2] : idx_q;
    f_we     = from_bus ? bus.we        : we_q;
    f_dat    = from_bus ? bus.dat_ms    : dat_q;
    f_sel    = from_bus ? bus.sel       : sel_q;
    f_hit    = ({1'b0, f_idx} < DepthW);
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    wcnt_d  = wcnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    tick_d  = 1'b0;
    fire    = 1'b0;
`ifdef WSHB_FRAME_PATTERN_EN
    pat_d   = pat_q;
`endif

    case (state_q)
      StIdle: begin
        if (req) begin
          idx_d  = bus.adr[31:2];
          we_d   = bus.we;
          dat_d  = bus.dat_ms;
          sel_d  = bus.sel;
          wcnt_d = WaitInit;
          if (WAIT_STATES == 0) begin
            fire = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (!req) begin
          state_d = StIdle;
          wcnt_d  = '0;
        end else if (wcnt_q == 4'd1) begin
          fire = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (fire) begin
      state_d = StResp;
      wcnt_d  = '0;
      if (f_we) begin
        if (f_hit) begin
          ack_d = 1'b1;
        end else begin
          err_d = 1'b1;
          src_d = DatZero;
        end
      end else if (f_hit) begin
        ack_d  = 1'b1;
        src_d  = DatRam;
        tick_d = (f_idx == LastIdx);
      end else begin
`ifdef WSHB_FRAME_PATTERN_EN
        ack_d  = 1'b1;
        src_d  = DatPat;
        pat_d  = {8'h00, f_idx[7:0], f_idx[15:8], f_idx[23:16]};
        tick_d = (f_idx == LastIdx);
`else
        err_d  = 1'b1;
        src_d  = DatZero;
`endif
      end
    end
  end

  assign ram_wr_en = fire & f_we & f_hit;
  assign ram_rd_en = fire & ~f_we & f_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      src_q   <= DatZero;
      wcnt_q  <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      dat_q   <= '0;
      sel_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      tick_q  <= 1'b0;
`ifdef WSHB_FRAME_PATTERN_EN
      pat_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      wcnt_q  <= wcnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      tick_q  <= tick_d;
`ifdef WSHB_FRAME_PATTERN_EN
      pat_q   <= pat_d;
`endif
    end
  end

  // Frame storage survives reset; the read register holds the last read word.
  always_ff @(posedge clk) begin
    if (ram_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (f_sel[b]) begin
          mem[f_idx[AW-1:0]][8*b +: 8] <= f_dat[8*b +: 8];
        end
      end
    end
    if (ram_rd_en) begin
      ram_rd_q <= mem[f_idx[AW-1:0]];
    end
  end

  always_comb begin
    bus.dat_sm = '0;
    case (src_q)
      DatRam:  bus.dat_sm = ram_rd_q;
`ifdef WSHB_FRAME_PATTERN_EN
      DatPat:  bus.dat_sm = pat_q;
`endif
      default: bus.dat_sm = '0;
    endcase
  end

  assign bus.ack    = ack_q;
  assign bus.err    = err_q;
  assign frame_tick = tick_q;

endmodule
